// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: widths, register
// count, FSM state encoding and a small helper for the wipe counter.
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREG   = 2 ** ADDR_W;

  // ARB: normal two-requester arbitration. WIPE: zeroing all registers.
  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_WIPE = 1'b1
  } state_e;

  // Last address visited by the wipe sweep; reaching it ends the sweep.
  localparam logic [ADDR_W-1:0] WIPE_LAST = ADDR_W'(NREG - 1);

  // True when the wipe counter is on the final register.
  function automatic logic is_wipe_last(input logic [ADDR_W-1:0] k);
    return (k == WIPE_LAST);
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of the requester handshakes, the wipe control and the register-file
// write port. The arbiter takes the slave view; the requesters/register file
// side (or a testbench) takes the master view.
interface regfile_wr_if;

  logic                          wipe_req;
  logic                          wipe_busy;

  logic                          req0_valid;
  logic [regfile_pkg::ADDR_W-1:0] req0_addr;
  logic [regfile_pkg::DATA_W-1:0] req0_data;
  logic                          req0_ready;

  logic                          req1_valid;
  logic [regfile_pkg::ADDR_W-1:0] req1_addr;
  logic [regfile_pkg::DATA_W-1:0] req1_data;
  logic                          req1_ready;

  logic                          rf_load;
  logic [regfile_pkg::ADDR_W-1:0] rf_caddr;
  logic [regfile_pkg::DATA_W-1:0] rf_cdata;

  // Arbiter side: consumes requests, drives grants and the write port.
  modport slave (
    input  wipe_req,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output wipe_busy,
    output req0_ready, req1_ready,
    output rf_load, rf_caddr, rf_cdata
  );

  // Requester / environment side.
  modport master (
    output wipe_req,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  wipe_busy,
    input  req0_ready, req1_ready,
    input  rf_load, rf_caddr, rf_cdata
  );

endinterface

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; when both are
// valid the one named by the pointer wins. Purely combinational.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      // Requester gi wins if it is valid and either alone or favoured.
      assign grant[gi] = valid[gi] & (~valid[1-gi] | (pointer == 1'(gi)));
    end
  endgenerate

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter. Two requesters share one registered write
// port under round-robin priority; a wipe request takes the port over for
// NREG cycles and writes zero to every register in address order.
module regfile_wr_arbiter
  import regfile_pkg::*;
(
  input  logic         clock,
  input  logic         clear,
  regfile_wr_if.slave  bus
);

  state_e              state_q;
  logic                ptr_q;
  logic [ADDR_W-1:0]   k_q;
  logic                rf_load_q;
  logic [ADDR_W-1:0]   rf_caddr_q;
  logic [DATA_W-1:0]   rf_cdata_q;

  logic [1:0]          valid_d;
  logic [1:0]          grant_d;
  logic [1:0]          ready_d;
  logic                arb_open_d;
  logic [ADDR_W-1:0]   win_addr_d;
  logic [DATA_W-1:0]   win_data_d;

  assign valid_d = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_rr_arb2 (
    .valid   (valid_d),
    .pointer (ptr_q),
    .grant   (grant_d)
  );

  // Grants are only exposed in ARB with no wipe starting and no reset, so a
  // cycle that launches a wipe never also accepts a transfer.
  always_comb begin
    arb_open_d = (state_q == ST_ARB) && !bus.wipe_req && !clear;
    ready_d    = arb_open_d ? grant_d : 2'b00;
    win_addr_d = grant_d[1] ? bus.req1_addr : bus.req0_addr;
    win_data_d = grant_d[1] ? bus.req1_data : bus.req0_data;
  end

  assign bus.req0_ready = ready_d[0];
  assign bus.req1_ready = ready_d[1];
  assign bus.wipe_busy  = (state_q == ST_WIPE);
  assign bus.rf_load    = rf_load_q;
  assign bus.rf_caddr   = rf_caddr_q;
  assign bus.rf_cdata   = rf_cdata_q;

  // Control FSM with registered write-port outputs; address/data hold
  // whenever no write is issued.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= ST_ARB;
      ptr_q      <= 1'b0;
      k_q        <= '0;
      rf_load_q  <= 1'b0;
      rf_caddr_q <= '0;
      rf_cdata_q <= '0;
    end else begin
      rf_load_q <= 1'b0;
      case (state_q)
        ST_ARB: begin
          if (bus.wipe_req) begin
            // k is already 0 here: it only wraps on leaving WIPE.
            state_q <= ST_WIPE;
          end else if (|grant_d) begin
            rf_load_q  <= 1'b1;
            rf_caddr_q <= win_addr_d;
            rf_cdata_q <= win_data_d;
            // Hand priority to the requester that did not just win.
            ptr_q      <= grant_d[0];
          end
        end
        ST_WIPE: begin
          rf_load_q  <= 1'b1;
          rf_caddr_q <= k_q;
          rf_cdata_q <= '0;
          k_q        <= k_q + ADDR_W'(1);
          if (is_wipe_last(k_q)) begin
            state_q <= ST_ARB;
          end
        end
        default: begin
          state_q <= ST_ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: reference model checks every cycle,
// plus a constant-expectation vector table and directed corner sequences.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  regfile_wr_if bus ();

  regfile_wr_arbiter dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining wipe writes, priority, expected write port.
  int          m_ptr  = 0;
  int          m_left = 0;
  logic        m_load = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [15:0] m_data = '0;

  function automatic logic [1:0] model_ready();
    if (clear || m_left > 0 || bus.wipe_req) return 2'b00;
    if (bus.req0_valid && bus.req1_valid) return (m_ptr == 0) ? 2'b01 : 2'b10;
    return {bus.req1_valid, bus.req0_valid};
  endfunction

  // One clock cycle: check grants, advance model, check registered outputs.
  task automatic tick();
    logic [1:0] er;
    #1;
    er = model_ready();
    chk("req0_ready", bus.req0_ready, er[0]);
    chk("req1_ready", bus.req1_ready, er[1]);
    if (clear) begin
      m_left = 0; m_ptr = 0; m_load = 0; m_addr = '0; m_data = '0;
    end else if (m_left > 0) begin
      m_load = 1; m_addr = 4'(NREG - m_left); m_data = '0; m_left--;
    end else if (bus.wipe_req) begin
      m_load = 0; m_left = NREG;
    end else if (er[0]) begin
      m_load = 1; m_addr = bus.req0_addr; m_data = bus.req0_data; m_ptr = 1;
    end else if (er[1]) begin
      m_load = 1; m_addr = bus.req1_addr; m_data = bus.req1_data; m_ptr = 0;
    end else begin
      m_load = 0;
    end
    @(posedge clock);
    #1;
    chk("rf_load", bus.rf_load, m_load);
    chk("rf_caddr", bus.rf_caddr, m_addr);
    chk("rf_cdata", bus.rf_cdata, m_data);
    chk("wipe_busy", bus.wipe_busy, (m_left > 0));
    if (bus.rf_load)
      $display("txn t=%0t write r%0d <= 0x%04h", $time, bus.rf_caddr, bus.rf_cdata);
  endtask

  task automatic idle_inputs();
    bus.wipe_req = 0;
    bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clear = 1;
    tick();
    tick();
    clear = 0;
  endtask

  typedef struct {
    logic v0, v1, clr;
    logic [3:0] a0, a1;
    logic [15:0] d0, d1;
    logic r0, r1;
  } vec_t;

  vec_t tbl[12];

  int          first_grant;
  int          grants;
  logic        busy_at[0:63];
  logic        load_at[0:63];
  logic [3:0]  addr_at[0:63];
  logic [15:0] data_at[0:63];

  initial begin
    // Expected grants derived by hand from the round-robin rules, pointer=0 after reset.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'd2,  4'd3,  16'h1111, 16'h2222, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'd5,  4'd6,  16'h5555, 16'h6666, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd7,  16'h0000, 16'h7777, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'd8,  4'd0,  16'h8888, 16'h0000, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'd9,  4'd0,  16'h9999, 16'h0000, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd10, 16'h0000, 16'hAAAA, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'd1,  4'd1,  16'h1234, 16'h4321, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 4'd11, 4'd12, 16'hBBBB, 16'hCCCC, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'd4,  4'd4,  16'hDEAD, 16'hBEEF, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'd13, 4'd14, 16'hDDDD, 16'hEEEE, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4'd15, 4'd0,  16'hFFFF, 16'h0F0F, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 4'd3,  4'd3,  16'h3333, 16'h3333, 1'b0, 1'b0};

    do_reset();
    chk("reset_rf_load", bus.rf_load, 0);
    chk("reset_rf_caddr", bus.rf_caddr, 0);
    chk("reset_rf_cdata", bus.rf_cdata, 0);
    chk("reset_wipe_busy", bus.wipe_busy, 0);

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      bus.req0_valid = tbl[i].v0; bus.req0_addr = tbl[i].a0; bus.req0_data = tbl[i].d0;
      bus.req1_valid = tbl[i].v1; bus.req1_addr = tbl[i].a1; bus.req1_data = tbl[i].d1;
      clear = tbl[i].clr;
      #1;
      chk($sformatf("tbl%0d_r0", i), bus.req0_ready, tbl[i].r0);
      chk($sformatf("tbl%0d_r1", i), bus.req1_ready, tbl[i].r1);
      tick();
      chk($sformatf("tbl%0d_load", i), bus.rf_load, tbl[i].r0 | tbl[i].r1);
      if (tbl[i].r0 | tbl[i].r1) begin
        chk($sformatf("tbl%0d_addr", i), bus.rf_caddr, tbl[i].r0 ? tbl[i].a0 : tbl[i].a1);
        chk($sformatf("tbl%0d_data", i), bus.rf_cdata, tbl[i].r0 ? tbl[i].d0 : tbl[i].d1);
      end else if (tbl[i].clr) begin
        chk($sformatf("tbl%0d_clr_addr", i), bus.rf_caddr, 0);
        chk($sformatf("tbl%0d_clr_data", i), bus.rf_cdata, 0);
      end
      clear = 0;
    end

    // Single requester, addr 1, data 0x4BC5.
    do_reset();
    tick();
    bus.req0_valid = 1; bus.req0_addr = 4'd1; bus.req0_data = 16'h4BC5;
    #1;
    chk("single_ready0", bus.req0_ready, 1);
    chk("single_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0;
    chk("single_load", bus.rf_load, 1);
    chk("single_addr", bus.rf_caddr, 1);
    chk("single_data", bus.rf_cdata, 16'h4BC5);

    // Contention: alternating grants 0,1,0,1 with one write per cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid = 1; bus.req0_addr = 4'(i);     bus.req0_data = 16'(16'hA000 + i);
      bus.req1_valid = 1; bus.req1_addr = 4'(8 + i); bus.req1_data = 16'(16'hB000 + i);
      #1;
      chk($sformatf("contend%0d_grant", i), {30'd0, bus.req1_ready, bus.req0_ready},
          (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk($sformatf("contend%0d_load", i), bus.rf_load, 1);
      chk($sformatf("contend%0d_addr", i), bus.rf_caddr, (i % 2 == 0) ? i : 8 + i);
    end
    idle_inputs();

    // Wipe pulse with req1 pending.
    do_reset();
    bus.req1_valid = 1; bus.req1_addr = 4'd9; bus.req1_data = 16'hBEEF;
    bus.wipe_req = 1;
    #1;
    chk("wipe_T_ready1", bus.req1_ready, 0);
    tick();
    bus.wipe_req = 0;
    first_grant = -1;
    for (int c = 1; c <= 18; c++) begin
      busy_at[c] = bus.wipe_busy;
      if (bus.req1_ready && first_grant < 0) first_grant = c;
      tick();
      load_at[c+1] = bus.rf_load; addr_at[c+1] = bus.rf_caddr; data_at[c+1] = bus.rf_cdata;
      if (first_grant == c) bus.req1_valid = 0;
    end
    chk("wipe_first_grant", first_grant, 17);
    for (int c = 1; c <= 17; c++) chk($sformatf("wipe_busy_T%0d", c), busy_at[c], (c <= 16));
    for (int c = 2; c <= 17; c++) begin
      chk($sformatf("wipe_load_T%0d", c), load_at[c], 1);
      chk($sformatf("wipe_addr_T%0d", c), addr_at[c], c - 2);
      chk($sformatf("wipe_data_T%0d", c), data_at[c], 0);
    end
    chk("wipe_req1_load", load_at[18], 1);
    chk("wipe_req1_addr", addr_at[18], 9);
    chk("wipe_req1_data", data_at[18], 16'hBEEF);
    idle_inputs();

    // Reset while the wipe counter is at 5.
    do_reset();
    bus.wipe_req = 1;
    tick();
    bus.wipe_req = 0;
    for (int c = 1; c <= 5; c++) tick();
    clear = 1;
    tick();
    clear = 0;
    chk("abort_load", bus.rf_load, 0);
    chk("abort_busy", bus.wipe_busy, 0);
    grants = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.rf_load) grants++;
    end
    chk("abort_no_writes", grants, 0);
    bus.req0_valid = 1; bus.req0_addr = 4'd6; bus.req0_data = 16'h0606;
    #1;
    chk("abort_arb_ready0", bus.req0_ready, 1);
    tick();
    idle_inputs();

    // wipe_req held for 20 cycles with req0 pending.
    do_reset();
    bus.req0_valid = 1; bus.req0_addr = 4'd3; bus.req0_data = 16'h3C3C;
    bus.wipe_req = 1;
    grants = 0;
    for (int c = 0; c < 20; c++) begin
      busy_at[c] = bus.wipe_busy;
      if (bus.req0_ready) grants++;
      tick();
      load_at[c+1] = bus.rf_load; addr_at[c+1] = bus.rf_caddr;
    end
    bus.wipe_req = 0;
    first_grant = -1;
    for (int c = 20; c <= 40; c++) begin
      if (bus.req0_ready && first_grant < 0) first_grant = c;
      tick();
      if (first_grant == c) bus.req0_valid = 0;
    end
    chk("held_no_grant", grants, 0);
    chk("held_busy_T17", busy_at[17], 0);
    chk("held_busy_T18", busy_at[18], 1);
    chk("held_second_load", load_at[19], 1);
    chk("held_second_addr", addr_at[19], 0);
    chk("held_first_grant", first_grant, 34);
    idle_inputs();

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bus.req0_valid = 1'($urandom_range(0, 1));
      bus.req0_addr  = 4'($urandom);
      bus.req0_data  = 16'($urandom);
      bus.req1_valid = 1'($urandom_range(0, 1));
      bus.req1_addr  = 4'($urandom);
      bus.req1_data  = 16'($urandom);
      bus.wipe_req   = ($urandom_range(0, 39) == 0);
      clear          = ($urandom_range(0, 79) == 0);
      tick();
    end
    clear = 0;
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter DATA_W, 16, register data width SHALL be this value.
REQ-002 Parameter ADDR_W, 4, register address width SHALL be this value.
REQ-003 Parameter NREG, 16, number of registers; SHALL equal 2**ADDR_W.
REQ-004 Port clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port clear  in  1  reset; SHALL be synchronous and active-high.
REQ-006 Port wipe_req  in  1  request to zero all NREG registers through the write port.
REQ-007 Port wipe_busy  out  1  SHALL be high while the wipe sequence runs.
REQ-008 Ports req0_valid, req1_valid  in  1 each  requester i has a pending write.
REQ-009 Ports req0_addr, req1_addr  in  ADDR_W each  destination register.
REQ-010 Ports req0_data, req1_data  in  DATA_W each  write data.
REQ-011 Ports req0_ready, req1_ready  out  1 each  combinational grant; transfer when valid and ready.
REQ-012 Port rf_load  out  1  register-file write enable, registered.
REQ-013 Port rf_caddr  out  ADDR_W  register-file write address, registered.
REQ-014 Port rf_cdata  out  DATA_W  register-file write data, registered.

Function
REQ-015 FSM SHALL have exactly two states: ARB and WIPE.
REQ-016 In ARB with wipe_req=0: at most one ready high per cycle; ready SHALL never assert without the matching valid.
REQ-017 Only one valid: that requester SHALL be granted, whatever the priority pointer.
REQ-018 Both valid: the requester named by the 1-bit priority pointer SHALL be granted.
REQ-019 After a grant to requester i, the pointer SHALL move to the other requester; with no grant it SHALL hold.
REQ-020 Accepted transfer in cycle T: rf_load=1, rf_caddr=addr, rf_cdata=data SHALL appear in cycle T+1 (latency 1).
REQ-021 Cycle without a transfer: rf_load SHALL be 0 next cycle; rf_caddr and rf_cdata SHALL hold.
REQ-022 Requesters SHALL hold valid, addr and data stable until ready; the arbiter does not check this.
REQ-023 wipe_req=1 in ARB in cycle T: both ready SHALL be 0 in T, and the state SHALL be WIPE from T+1.
REQ-024 In WIPE: both ready SHALL be 0, and a 4-bit counter k SHALL run 0..15, one step per cycle.
REQ-025 WIPE data bus: during cycle T+2+k, rf_load=1, rf_caddr=k and rf_cdata=0, for k=0..15.
REQ-026 wipe_busy SHALL be high in cycles T+1..T+16 exactly.
REQ-027 After k=15 the state SHALL be ARB at T+17; the first grant may occur in T+17.
REQ-028 wipe_req SHALL be ignored while in WIPE; a level still high on return to ARB SHALL start a new wipe.
REQ-029 The priority pointer SHALL be unchanged by a wipe.
REQ-030 Write addresses SHALL be used unmodified; the counter SHALL wrap 15->0 only on exit from WIPE.

Reset
REQ-031 With clear=1 at a rising edge, the next cycle SHALL have: state ARB, pointer=0, k=0, wipe_busy=0, rf_load=0, rf_caddr=0, rf_cdata=0.
REQ-032 clear SHALL take precedence over all other inputs; both ready SHALL be 0 while clear=1.
REQ-033 clear during WIPE SHALL abort the sequence; no further wipe writes SHALL be issued.

Structure
REQ-034 DATA_W, ADDR_W, NREG and the state enum SHALL live in shared package regfile_pkg.
REQ-035 Two-way round-robin grant logic SHALL be sub-module rr_arb2: inputs valid[1:0] and pointer, output grant[1:0].
REQ-036 There SHALL be no other sub-modules.

Verification
REQ-037 Single requester: req0 valid, addr=1, data=0x4BC5 in cycle 3 -> req0_ready=1 in cycle 3; rf_load=1, rf_caddr=1, rf_cdata=0x4BC5 in cycle 4.
REQ-038 Contention: both valid for 4 cycles after reset -> grants in order 0, 1, 0, 1, one write per cycle.
REQ-039 Wipe: wipe_req pulse in cycle T with req1 valid -> req1_ready=0 until T+17; rf_caddr=0..15 and rf_cdata=0 in T+2..T+17; req1 written in T+18.
REQ-040 Reset mid-wipe: clear at k=5 -> next cycle rf_load=0, wipe_busy=0, state ARB, no write to address 6.
REQ-041 Held wipe_req: wipe_req high for 20 cycles -> a second wipe starts immediately at return to ARB; no grant issued in between.
